// File: rtl/eth_phy_10g_rx_descramble_ber_pkg.sv
// Shared 10GBASE-R receive-side PHY definitions: BER monitor states,
// sync-header codes and the self-synchronous scrambler taps.
package eth_phy_10g_rx_descramble_ber_pkg;

  // Sync-header codes carried in front of every 64-bit block.
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Scrambler polynomial 1 + x^39 + x^58.
  localparam int SCR_TAP_A = 39;
  localparam int SCR_TAP_B = 58;

  // BER monitor states, one-hot.
  typedef enum logic [2:0] {
    BER_INIT  = 3'b001,
    BER_COUNT = 3'b010,
    BER_HIGH  = 3'b100
  } ber_state_t;

  // A header is only valid when it is one of the two legal sync codes.
  function automatic logic hdr_invalid(input logic [1:0] hdr);
    return !((hdr == SYNC_DATA) || (hdr == SYNC_CTRL));
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_descramble_ber_descrambler.sv
// Self-synchronous 1 + x^39 + x^58 descrambler, one block per clock.
// Bit 0 of each block is the earliest bit on the line; the 58-bit
// history holds the most recently received scrambled bits, with the
// newest bit at the top.
module eth_phy_10g_descrambler
  import eth_phy_10g_rx_descramble_ber_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] scr_data,
  output logic [DATA_W-1:0] dscr_data
);

  localparam int HIST_W = SCR_TAP_B;
  localparam int EXT_W  = DATA_W + HIST_W;

  logic [HIST_W-1:0] hist_p0;
  logic [EXT_W-1:0]  ext;
  logic [DATA_W-1:0] dscr;

  // Line-ordered view: history below, current block above.
  assign ext = {scr_data, hist_p0};

  // Each output bit cancels the two taps 39 and 58 bits earlier on the line.
  always_comb begin
    dscr = '0;
    for (int i = 0; i < DATA_W; i++) begin
      dscr[i] = ext[i + HIST_W] ^ ext[i + HIST_W - SCR_TAP_A] ^ ext[i + HIST_W - SCR_TAP_B];
    end
  end

  // Stage p0 -> p1: keep the newest 58 scrambled bits and register the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_p0   <= '0;
      dscr_data <= '0;
    end else begin
      hist_p0   <= ext[EXT_W-1 -: HIST_W];
      dscr_data <= dscr;
    end
  end

endmodule

// File: rtl/eth_phy_10g_rx_descramble_ber.sv
// 10GBASE-R receive descrambler with high-BER monitor. Payload goes
// through the descrambler sub-module with one cycle of latency, the
// sync header is delayed to match, and invalid headers are counted
// per 125 us window to raise the high-BER status.
module eth_phy_10g_rx_descramble_ber
  import eth_phy_10g_rx_descramble_ber_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 2,
  parameter int COUNT_125US = 19531,
  parameter int BER_LIMIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_serdes_rx_data,
  input  logic [HDR_WIDTH-1:0]  i_serdes_rx_hdr,
  input  logic                  i_rx_block_lock,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic [HDR_WIDTH-1:0]  o_rx_hdr,
  output logic                  o_rx_high_ber,
  output logic [5:0]            o_rx_ber_cnt
);

  localparam int                 TIMER_W    = (COUNT_125US > 1) ? $clog2(COUNT_125US) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(COUNT_125US - 1);
  localparam logic [5:0]         CNT_MAX    = 6'd63;
  localparam logic [6:0]         LIMIT      = 7'(BER_LIMIT);

  ber_state_t         state;
  logic [TIMER_W-1:0] timer;
  logic [5:0]         ber_cnt;
  logic               hi_ber;
  logic [HDR_WIDTH-1:0] hdr_p1;

  logic       hdr_bad;
  logic       win_end;
  logic [5:0] cnt_next;

  // Saturating increment of the invalid-header counter.
  function automatic logic [5:0] sat_inc(input logic [5:0] cnt, input logic inc);
    if (inc && (cnt != CNT_MAX)) begin
      return cnt + 6'd1;
    end
    return cnt;
  endfunction

  eth_phy_10g_descrambler #(
    .DATA_W (DATA_WIDTH)
  ) u_descrambler (
    .clk       (clk),
    .rst       (rst),
    .scr_data  (i_serdes_rx_data),
    .dscr_data (o_rx_data)
  );

  // Stage p0 -> p1: header travels alongside the descrambled payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_p1 <= '0;
    end else begin
      hdr_p1 <= i_serdes_rx_hdr;
    end
  end

  assign o_rx_hdr = hdr_p1;

  // Per-cycle header classification and the count including this header.
  always_comb begin
    hdr_bad  = hdr_invalid(i_serdes_rx_hdr);
    win_end  = (timer == TIMER_LAST);
    cnt_next = sat_inc(ber_cnt, hdr_bad);
  end

  // BER window FSM: lock loss wins over every other event; at window end the
  // closing count (including the window-end header) decides high-BER for the
  // next window, mid-window the registered count promotes COUNT to HIGH.
  always_ff @(posedge clk) begin
    if (rst || !i_rx_block_lock) begin
      state   <= BER_INIT;
      timer   <= '0;
      ber_cnt <= '0;
      hi_ber  <= 1'b0;
    end else begin
      unique case (state)
        BER_INIT: begin
          state   <= BER_COUNT;
          timer   <= '0;
          ber_cnt <= '0;
          hi_ber  <= 1'b0;
        end
        BER_COUNT, BER_HIGH: begin
          if (win_end) begin
            timer   <= '0;
            ber_cnt <= '0;
            if ({1'b0, cnt_next} >= LIMIT) begin
              state  <= BER_HIGH;
              hi_ber <= 1'b1;
            end else begin
              state  <= BER_COUNT;
              hi_ber <= 1'b0;
            end
          end else begin
            timer   <= timer + 1'b1;
            ber_cnt <= cnt_next;
            if ((state == BER_COUNT) && ({1'b0, ber_cnt} >= LIMIT)) begin
              state  <= BER_HIGH;
              hi_ber <= 1'b1;
            end
          end
        end
        default: begin
          state   <= BER_INIT;
          timer   <= '0;
          ber_cnt <= '0;
          hi_ber  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_high_ber = hi_ber;
  assign o_rx_ber_cnt  = ber_cnt;

endmodule

// File: tb/tb_eth_phy_10g_rx_descramble_ber.sv
// Randomized bench for eth_phy_10g_rx_descramble_ber: payloads are
// scrambled by a bit-serial reference scrambler, and outputs are compared
// every cycle against a window-level BER model and a bit-serial
// descrambler model.
module tb_eth_phy_10g_rx_descramble_ber;

  localparam int DW  = 64;
  localparam int HW  = 2;
  localparam int WIN = 100;
  localparam int LIM = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_serdes_rx_data;
  logic [HW-1:0] i_serdes_rx_hdr;
  logic          i_rx_block_lock;
  logic [DW-1:0] o_rx_data;
  logic [HW-1:0] o_rx_hdr;
  logic          o_rx_high_ber;
  logic [5:0]    o_rx_ber_cnt;

  always #5 clk = ~clk;

  eth_phy_10g_rx_descramble_ber #(
    .DATA_WIDTH  (DW),
    .HDR_WIDTH   (HW),
    .COUNT_125US (WIN),
    .BER_LIMIT   (LIM)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_serdes_rx_data (i_serdes_rx_data),
    .i_serdes_rx_hdr  (i_serdes_rx_hdr),
    .i_rx_block_lock  (i_rx_block_lock),
    .o_rx_data        (o_rx_data),
    .o_rx_hdr         (o_rx_hdr),
    .o_rx_high_ber    (o_rx_high_ber),
    .o_rx_ber_cnt     (o_rx_ber_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference scrambler line history (seeded all ones) and receiver model.
  bit tx_q[$];
  bit rx_q[$];

  bit          m_run;
  bit          m_high;
  int          m_pos;
  int          m_cnt;
  logic [63:0] m_data;
  logic [1:0]  m_hdr;
  logic [63:0] m_pay;
  int          m_blocks;

  function automatic logic [63:0] scramble(input logic [63:0] pay);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 64; i++) begin
      int n;
      n = tx_q.size();
      s[i] = pay[i] ^ tx_q[n-39] ^ tx_q[n-58];
      tx_q.push_back(s[i]);
    end
    while (tx_q.size() > 58) void'(tx_q.pop_front());
    return s;
  endfunction

  task automatic model_step(input bit r, input bit l, input logic [1:0] h,
                            input logic [63:0] scr, input logic [63:0] pay);
    int closing;
    bit bad;
    if (r) begin
      m_data = '0;
      m_hdr  = '0;
      rx_q.delete();
      for (int i = 0; i < 58; i++) rx_q.push_back(1'b0);
      m_blocks = 0;
      m_run = 0; m_high = 0; m_pos = 0; m_cnt = 0;
      return;
    end
    for (int i = 0; i < 64; i++) begin
      int n;
      n = rx_q.size();
      m_data[i] = scr[i] ^ rx_q[n-39] ^ rx_q[n-58];
      rx_q.push_back(scr[i]);
    end
    while (rx_q.size() > 58) void'(rx_q.pop_front());
    m_hdr = h;
    m_pay = pay;
    m_blocks++;
    if (!l) begin
      m_run = 0; m_high = 0; m_pos = 0; m_cnt = 0;
    end else if (!m_run) begin
      m_run = 1; m_pos = 0; m_cnt = 0;
    end else begin
      bad = (h == 2'b00) || (h == 2'b11);
      closing = (m_cnt + int'(bad) > 63) ? 63 : m_cnt + int'(bad);
      if (m_pos == WIN - 1) begin
        m_high = (closing >= LIM);
        m_pos  = 0;
        m_cnt  = 0;
      end else begin
        m_high = m_high || (m_cnt >= LIM);
        m_cnt  = closing;
        m_pos++;
      end
    end
  endtask

  // mode 0: all valid; 1: 2'b11 at window positions < k;
  // 2: invalid at positions < k and on the window-end cycle; 3: k percent invalid.
  function automatic logic [1:0] pick_hdr(input int mode, input int k);
    logic [1:0] good, bad;
    good = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    bad  = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
    case (mode)
      1:       return (m_run && m_pos < k) ? 2'b11 : good;
      2:       return (m_run && (m_pos < k || m_pos == WIN - 1)) ? bad : good;
      3:       return (int'($urandom_range(0, 99)) < k) ? bad : good;
      default: return good;
    endcase
  endfunction

  task automatic step(input bit r, input bit l, input logic [1:0] h, input bit zero_pay);
    logic [63:0] pay, scr;
    pay = zero_pay ? 64'd0 : {$urandom, $urandom};
    scr = scramble(pay);
    rst = r;
    i_rx_block_lock  = l;
    i_serdes_rx_hdr  = h;
    i_serdes_rx_data = scr;
    model_step(r, l, h, scr, pay);
    @(negedge clk);
    check("data",   o_rx_data, m_data);
    check("hdr",    64'(o_rx_hdr), 64'(m_hdr));
    check("hi_ber", 64'(o_rx_high_ber), 64'(m_high));
    check("ber_cnt", 64'(o_rx_ber_cnt), 64'(m_cnt));
    if (m_blocks >= 2) check("payload", o_rx_data, m_pay);
  endtask

  task automatic run(input int mode, input int k, input int cycles);
    for (int c = 0; c < cycles; c++) step(1'b0, 1'b1, pick_hdr(mode, k), 1'b0);
  endtask

  // Advance with valid headers until the next cycle is window position 0.
  task automatic align();
    for (int c = 0; c < 2 * WIN && !(m_run && m_pos == 0); c++)
      step(1'b0, 1'b1, pick_hdr(0, 0), 1'b0);
    check("align", 64'(m_run && m_pos == 0), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 58; i++) tx_q.push_back(1'b1);
    rst = 1'b1;
    i_rx_block_lock  = 1'b0;
    i_serdes_rx_hdr  = 2'b00;
    i_serdes_rx_data = '0;

    // Reset, then idle all-zero blocks through the reference scrambler.
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 2'b11, 1'b1);
    for (int c = 0; c < 20; c++) step(1'b0, 1'b1, pick_hdr(0, 0), 1'b1);

    // 15 invalid per window: count peaks at 15, never high.
    align();
    run(1, 15, 2 * WIN);
    // 16 invalid at positions 0..15: high, then a clean window clears it.
    align();
    run(1, 16, WIN);
    run(0, 0, WIN + 5);
    // 16th invalid on the window-end cycle.
    align();
    run(2, 15, 2 * WIN);
    run(0, 0, 2 * WIN);
    // High, then lock loss and relock.
    align();
    run(1, 20, WIN + 10);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, pick_hdr(3, 50), 1'b0);
    run(1, 5, WIN + 10);
    // Reset pulse with ber_cnt = 10 mid-window.
    align();
    run(1, 10, 12);
    check("cnt_before_rst", 64'(o_rx_ber_cnt), 64'd10);
    step(1'b1, 1'b1, 2'b11, 1'b0);
    run(1, 3, WIN + 10);
    // Whole window invalid: counter saturates at 63.
    align();
    run(1, WIN, WIN + 5);
    // Random error density with occasional lock loss and reset.
    for (int c = 0; c < 15 * WIN; c++) begin
      bit r, l;
      r = ($urandom_range(0, 399) == 0);
      l = ($urandom_range(0, 149) != 0);
      step(r, l, pick_hdr(3, (c / WIN) * 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_phy_10g_rx_descramble_ber.md
ETH_PHY_10G_RX_DESCRAMBLE_BER -- requirements
Module: eth_phy_10g_rx_descramble_ber

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 64, payload width; HDR_WIDTH, 2, sync-header width; COUNT_125US, 19531, clk cycles per 125 us BER window (156.25 MHz block clock); BER_LIMIT, 16, invalid headers per window that declare hi_ber.
REQ-002 Ports SHALL be: clk  in  1  block clock; rst  in  1  reset.
REQ-003 Ports SHALL be: i_serdes_rx_data  in  DATA_WIDTH  aligned scrambled payload from the frame aligner, bit 0 first on the line.
REQ-004 Ports SHALL be: i_serdes_rx_hdr  in  HDR_WIDTH  aligned sync header.
REQ-005 Ports SHALL be: i_rx_block_lock  in  1  aligner lock status.
REQ-006 Ports SHALL be: o_rx_data  out  DATA_WIDTH  descrambled payload; o_rx_hdr  out  HDR_WIDTH  header delayed to match.
REQ-007 Ports SHALL be: o_rx_high_ber  out  1  high-BER status; o_rx_ber_cnt  out  6  invalid headers in the current window, saturating at 63.
REQ-008 The block SHALL use one clock; reset is synchronous and active-high.

Function
REQ-009 A new block SHALL be accepted on every clk cycle; there is no valid/ready handshake.
REQ-010 Descrambler SHALL implement the self-synchronous polynomial 1 + x^39 + x^58: out[i] = in[i] ^ in[i-39] ^ in[i-58], with bit indices spanning the current block and the 58-bit history.
REQ-011 The history register SHALL hold the last 58 received (scrambled) bits and update every cycle regardless of header value or lock.
REQ-012 o_rx_data and o_rx_hdr SHALL be registered with exactly 1 cycle of latency from the inputs; the header SHALL pass through unmodified.
REQ-013 A header SHALL be invalid when it equals 2'b00 or 2'b11; 2'b01 and 2'b10 are valid.
REQ-014 The BER FSM SHALL have states BER_INIT, BER_COUNT and BER_HIGH, one-hot encoded.
REQ-015 BER_INIT: clear timer and ber_cnt, drive hi_ber=0; go to BER_COUNT on the next cycle when i_rx_block_lock=1.
REQ-016 The timer SHALL count 0..COUNT_125US-1 while in BER_COUNT or BER_HIGH; the cycle with timer=COUNT_125US-1 is the window-end cycle.
REQ-017 Each invalid header seen in BER_COUNT or BER_HIGH SHALL increment ber_cnt (6 bits, saturating at 63).
REQ-018 BER_COUNT -> BER_HIGH SHALL occur in the cycle that ber_cnt reaches BER_LIMIT; hi_ber=1 from the next cycle.
REQ-019 At window end, the timer and ber_cnt SHALL clear, and the window-end cycle's header SHALL count toward the closing window.
REQ-020 At window end in BER_HIGH, the FSM SHALL go to BER_COUNT (hi_ber=0) if the closing count < BER_LIMIT, else stay in BER_HIGH.
REQ-021 i_rx_block_lock=0 in any state SHALL force BER_INIT next cycle; this has priority over window-end and BER_LIMIT events in the same cycle.
REQ-022 o_rx_ber_cnt SHALL equal the registered ber_cnt.

Reset
REQ-023 On rst=1, FSM=BER_INIT; timer, ber_cnt and history=0; o_rx_data=0, o_rx_hdr=0, o_rx_high_ber=0, o_rx_ber_cnt=0.
REQ-024 Reset mid-window SHALL discard the partial window, and counting SHALL restart from 0 after rst deasserts with lock high.

Structure
REQ-025 The shared PHY package SHALL hold the FSM state constants, the SYNC_DATA=2'b01 and SYNC_CTRL=2'b10 constants, and the polynomial taps 39 and 58.
REQ-026 The descrambler SHALL be a sub-module, eth_phy_10g_descrambler, with 1-cycle latency; the BER FSM SHALL stay in the top module.

Verification
REQ-027 Scramble a known payload (e.g. all-zero idle blocks) with a reference scrambler seeded 58'h3FF_FFFF_FFFF_FFFF -> o_rx_data matches the original payload from the 2nd block onward, with 1-cycle latency.
REQ-028 Lock high, 15 invalid headers (2'b11) within one window (COUNT_125US=100 for sim) -> o_rx_high_ber stays 0, and o_rx_ber_cnt=15 then clears to 0 after window end.
REQ-029 16 invalid headers in cycles 0..15 -> o_rx_high_ber=1 from cycle 17; next window with 0 invalid headers -> returns to 0 one cycle after window end.
REQ-030 Invalid header on window-end cycle as the 16th -> o_rx_high_ber=1 and ber_cnt counts it, then clears.
REQ-031 o_rx_high_ber=1, then i_rx_block_lock drops to 0 -> o_rx_high_ber=0 and o_rx_ber_cnt=0 next cycle; relock restarts the window at timer 0.
REQ-032 rst pulsed for 1 cycle mid-window with ber_cnt=10 -> all outputs 0 next cycle, and the count restarts from 0.
